// File: rtl/ariane_pkg.sv
// Shared decode/issue types; only the scoreboard entry is needed by the issue buffer.
package ariane_pkg;

  typedef enum logic [3:0] {
    FU_NONE,
    FU_LOAD,
    FU_STORE,
    FU_ALU,
    FU_CTRL_FLOW,
    FU_MULT,
    FU_CSR,
    FU_FPU
  } fu_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  trans_id;
    fu_t         fu;
    logic [6:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        valid;
    logic        use_imm;
  } scoreboard_entry_t;

endpackage

// File: rtl/issue_entry_buffer.sv
// In-order decode-to-issue FIFO of scoreboard entries with a head+1 lookahead port.
// DEPTH must be a power of two >= 2 so both pointers wrap by plain overflow.
module issue_entry_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  ariane_pkg::scoreboard_entry_t decoded_entry_i,
  input  logic                          decoded_valid_i,
  input  logic                          decoded_is_ctrl_flow_i,
  output logic                          decoded_ack_o,
  output ariane_pkg::scoreboard_entry_t issue_entry_o,
  output logic                          issue_entry_valid_o,
  output logic                          is_ctrl_flow_o,
  input  logic                          issue_instr_ack_i,
  output ariane_pkg::scoreboard_entry_t next_entry_o,
  output logic                          next_entry_valid_o,
  output logic [$clog2(DEPTH):0]        count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  typedef struct packed {
    ariane_pkg::scoreboard_entry_t sbe;
    logic                          is_ctrl_flow;
  } slot_t;

  slot_t           mem_q [DEPTH];
  logic [PtrW-1:0] rptr_q;
  logic [PtrW-1:0] wptr_q;
  logic [CntW-1:0] count_q;
  logic [PtrW-1:0] rptr_next;
  slot_t           head_slot;
  slot_t           next_slot;
  logic            push;
  logic            pop;

  // Acceptance looks only at registered occupancy, so a full buffer refuses
  // even while it is being drained in the same cycle.
  assign decoded_ack_o       = (count_q != FullCount);
  assign issue_entry_valid_o = (count_q != '0);
  assign push                = decoded_valid_i && decoded_ack_o;
  assign pop                 = issue_entry_valid_o && issue_instr_ack_i;

  assign rptr_next = rptr_q + PtrW'(1);
  assign head_slot = mem_q[rptr_q];
  assign next_slot = mem_q[rptr_next];

  assign issue_entry_o      = head_slot.sbe;
  assign is_ctrl_flow_o     = head_slot.is_ctrl_flow;
  assign next_entry_o       = next_slot.sbe;
  assign next_entry_valid_o = (count_q >= CntW'(2)) && !head_slot.is_ctrl_flow;
  assign count_o            = count_q;

  // Flush only rewinds pointers and count; stale array contents are harmless
  // because every valid is derived from the count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      mem_q   <= '{default: '0};
    end else if (flush_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= '{sbe: decoded_entry_i, is_ctrl_flow: decoded_is_ctrl_flow_i};
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_next;
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_issue_entry_buffer.sv
// Randomized and directed bench for issue_entry_buffer against a queue-based reference model.
module tb_issue_entry_buffer;

  localparam int unsigned DEPTH = 4;
  typedef ariane_pkg::scoreboard_entry_t sbe_t;
  typedef struct {
    sbe_t sbe;
    logic ctrl;
  } model_slot_t;

  logic                   clk_i = 1'b0;
  logic                   rst_i = 1'b1;
  logic                   flush_i = 1'b0;
  sbe_t                   decoded_entry_i = '0;
  logic                   decoded_valid_i = 1'b0;
  logic                   decoded_is_ctrl_flow_i = 1'b0;
  logic                   decoded_ack_o;
  sbe_t                   issue_entry_o;
  logic                   issue_entry_valid_o;
  logic                   is_ctrl_flow_o;
  logic                   issue_instr_ack_i = 1'b0;
  sbe_t                   next_entry_o;
  logic                   next_entry_valid_o;
  logic [$clog2(DEPTH):0] count_o;

  model_slot_t model_q[$];
  int          n_compared = 0;
  int          n_mismatched = 0;
  logic        after_reset = 1'b1;

  issue_entry_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .flush_i                (flush_i),
    .decoded_entry_i        (decoded_entry_i),
    .decoded_valid_i        (decoded_valid_i),
    .decoded_is_ctrl_flow_i (decoded_is_ctrl_flow_i),
    .decoded_ack_o          (decoded_ack_o),
    .issue_entry_o          (issue_entry_o),
    .issue_entry_valid_o    (issue_entry_valid_o),
    .is_ctrl_flow_o         (is_ctrl_flow_o),
    .issue_instr_ack_i      (issue_instr_ack_i),
    .next_entry_o           (next_entry_o),
    .next_entry_valid_o     (next_entry_valid_o),
    .count_o                (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic sbe_t random_entry();
    logic [$bits(sbe_t)-1:0] bits;
    for (int i = 0; i < $bits(sbe_t); i++) bits[i] = 1'($urandom_range(0, 1));
    return sbe_t'(bits);
  endfunction

  function automatic sbe_t entry_with_rd(input logic [4:0] rd);
    sbe_t e;
    e    = random_entry();
    e.rd = rd;
    return e;
  endfunction

  // Expected outputs follow directly from the model queue contents.
  task automatic compareToModel();
    int sz;
    sz = model_q.size();
    checkOutput("count", 256'(count_o), 256'(sz));
    checkOutput("head_valid", 256'(issue_entry_valid_o), 256'(sz != 0));
    checkOutput("decoded_ack", 256'(decoded_ack_o), 256'(sz != DEPTH));
    checkOutput("next_valid", 256'(next_entry_valid_o), 256'(sz >= 2 && !model_q[0].ctrl));
    if (sz >= 1) begin
      checkOutput("head_entry", 256'(issue_entry_o), 256'(model_q[0].sbe));
      checkOutput("head_ctrl", 256'(is_ctrl_flow_o), 256'(model_q[0].ctrl));
    end
    if (sz >= 2) begin
      checkOutput("next_entry", 256'(next_entry_o), 256'(model_q[1].sbe));
    end
    if (after_reset) begin
      checkOutput("reset_head_entry", 256'(issue_entry_o), 256'(0));
      checkOutput("reset_next_entry", 256'(next_entry_o), 256'(0));
      checkOutput("reset_ctrl", 256'(is_ctrl_flow_o), 256'(0));
    end
  endtask

  // Drives one cycle of inputs, lets one edge pass, advances the model and checks.
  task automatic applyStimulus(input logic valid, input sbe_t entry, input logic ctrl,
                               input logic ack, input logic flush);
    logic accept;
    logic take;
    decoded_valid_i        = valid;
    decoded_entry_i        = entry;
    decoded_is_ctrl_flow_i = ctrl;
    issue_instr_ack_i      = ack;
    flush_i                = flush;
    accept = valid && (model_q.size() != DEPTH);
    take   = ack && (model_q.size() != 0);
    @(posedge clk_i);
    #1;
    if (flush) begin
      model_q.delete();
    end else begin
      if (take) void'(model_q.pop_front());
      if (accept) model_q.push_back('{sbe: entry, ctrl: ctrl});
    end
    if (valid || flush) after_reset = 1'b0;
    decoded_valid_i   = 1'b0;
    issue_instr_ack_i = 1'b0;
    flush_i           = 1'b0;
    compareToModel();
  endtask

  initial begin
    sbe_t e;
    int   ack_pct;

    #12 rst_i = 1'b0;
    compareToModel();

    // Single push of entry A with rd=5.
    applyStimulus(1'b1, entry_with_rd(5'd5), 1'b0, 1'b0, 1'b0);
    checkOutput("push_a_rd", 256'(issue_entry_o.rd), 256'(5));

    // Fill to DEPTH, offer a fifth entry, then drain.
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b1, random_entry(), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, random_entry(), 1'b0, 1'b0, 1'b0);
    checkOutput("full_count", 256'(count_o), 256'(DEPTH));
    applyStimulus(1'b1, random_entry(), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b0, random_entry(), 1'b0, 1'b1, 1'b0);
    checkOutput("drained_valid", 256'(issue_entry_valid_o), 256'(0));

    // Streaming push+ack at occupancy 1 across several pointer wraps.
    applyStimulus(1'b1, random_entry(), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, random_entry(), 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, random_entry(), 1'b0, 1'b1, 1'b0);

    // Lookahead gating behind a branch, then behind a load.
    applyStimulus(1'b1, random_entry(), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, random_entry(), 1'b0, 1'b0, 1'b0);
    checkOutput("gate_branch", 256'(next_entry_valid_o), 256'(0));
    applyStimulus(1'b0, random_entry(), 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, random_entry(), 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, random_entry(), 1'b0, 1'b0, 1'b0);
    checkOutput("gate_load", 256'(next_entry_valid_o), 256'(1));

    // Flush colliding with push and ack at count=3.
    applyStimulus(1'b1, random_entry(), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, random_entry(), 1'b0, 1'b1, 1'b1);
    checkOutput("flush_count", 256'(count_o), 256'(0));

    // Asynchronous reset between edges with two entries queued.
    applyStimulus(1'b1, random_entry(), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, random_entry(), 1'b0, 1'b0, 1'b0);
    #1 rst_i = 1'b1;
    #1;
    model_q.delete();
    after_reset = 1'b1;
    checkOutput("async_rst_valid", 256'(issue_entry_valid_o), 256'(0));
    compareToModel();
    #1 rst_i = 1'b0;
    e = random_entry();
    applyStimulus(1'b1, e, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_head", 256'(issue_entry_o), 256'(e));

    // Randomized traffic with varying consumer pressure and occasional flushes.
    ack_pct = 50;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) ack_pct = int'($urandom_range(10, 95));
      applyStimulus(1'($urandom_range(0, 99) < 70), random_entry(),
                    1'($urandom_range(0, 99) < 25),
                    1'($urandom_range(0, 99) < ack_pct),
                    1'($urandom_range(0, 99) < 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
